// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider.
// Each channel divides the system clock by a runtime-programmable ratio N and
// produces a registered divided clock (high for ceil(N/2) cycles, low for
// floor(N/2) cycles) plus a one-cycle tick after each period wrap. New divisors
// are held pending and swapped in at a period boundary so no runt period is
// ever emitted; idle or degenerate (N=0/1) channels take a new divisor at once.
module multi_clk_divider #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    // Divisor swap state: IDLE = active divisor current, PENDING = a write
    // is waiting for the next period wrap.
    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_t;

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        swap_state_t      st_q, st_d;

        logic [CNT_W-1:0] last;
        logic [CNT_W-1:0] half_hi;
        logic [CNT_W-1:0] cnt_inc;
        logic             run;
        logic             single;
        logic             wrap;
        logic             idle_ch;
        logic             wr_hit;

        // Per-channel decode: period limits, run mode and write targeting.
        // Indices at or above NUM_CH never match any channel, so such writes
        // are dropped without an explicit range check.
        always_comb begin
            last    = div_q - ONE;
            half_hi = div_q - (div_q >> 1);
            run     = en[c] && (div_q >= TWO);
            single  = en[c] && (div_q == ONE);
            idle_ch = !en[c] || (div_q < TWO);
            wrap    = run && (cnt_q == last);
            cnt_inc = wrap ? '0 : cnt_q + ONE;
            wr_hit  = wr_en && (wr_ch == CH_W'(c));
        end

        // Counter and output next-state: stopped/disabled channels hold zero,
        // N=1 ticks every cycle, N>=2 runs the normal period.
        always_comb begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
            if (run) begin
                cnt_d  = cnt_inc;
                clk_d  = (cnt_inc < half_hi);
                tick_d = wrap;
            end else if (single) begin
                tick_d = 1'b1;
            end
        end

        // Divisor swap next-state. A write on the wrap edge itself keeps the
        // current divisor and re-arms the pending state for the next wrap.
        always_comb begin
            st_d   = st_q;
            div_d  = div_q;
            pend_d = pend_q;
            case (st_q)
                SWAP_IDLE: ;
                SWAP_PENDING: begin
                    if (wrap || idle_ch) begin
                        div_d = pend_q;
                        st_d  = SWAP_IDLE;
                    end
                end
                default: st_d = SWAP_IDLE;
            endcase
            if (wr_hit) begin
                pend_d = wr_div;
                if (idle_ch) begin
                    div_d = wr_div;
                    st_d  = SWAP_IDLE;
                end else begin
                    div_d = div_q;
                    st_d  = SWAP_PENDING;
                end
            end
        end

        // Channel state registers with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                div_q  <= DEF_DIV;
                pend_q <= DEF_DIV;
                st_q   <= SWAP_IDLE;
            end else begin
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                div_q  <= div_d;
                pend_q <= pend_d;
                st_q   <= st_d;
            end
        end

        assign clk_out[c] = clk_q;
        assign tick[c]    = tick_q;
        assign busy[c]    = (st_q == SWAP_PENDING);

    end

endmodule
